// File: rtl/dmem_ctrl.sv
// RV32 byte-addressable data memory (LB/LH/LW/LBU/LHU/SB/SH/SW); DMEM_MISALIGN_TRAP_EN traps misaligned H/W accesses.
// Latency: accept at edge T -> valid_o in cycle T+1+WAIT_STATES; memory is zeroed (one word per cycle) after reset.
// Backpressure: ready_o only in IDLE; req_i at other times is dropped, not queued.
module dmem_ctrl #(
    parameter int DEPTH_BYTES = 1024,
    parameter int ADDR_W      = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk_i,
    input  logic              reset,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [2:0]        funct3_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       data_i,
    output logic              ready_o,
    output logic              valid_o,
    output logic [31:0]       data_o,
    output logic              err_o,
    output logic              init_done_o,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    output logic [31:0]       dbg_data_o
);

    localparam int AW = $clog2(DEPTH_BYTES);
    localparam int WW = AW - 2;

    localparam logic [1:0] CLEAR = 2'd0;
    localparam logic [1:0] IDLE  = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]        state;
    logic [WW-1:0]     clr_cnt;
    logic [3:0]        wait_cnt;
    logic              init_done;
    logic              lat_we;
    logic [2:0]        lat_f3;
    logic [ADDR_W-1:0] lat_addr;
    logic [31:0]       lat_data;

    logic [7:0] mem [DEPTH_BYTES];

    logic [2:0]    acc_size;
    logic [ADDR_W:0] last_byte;
    logic          range_err;
    logic          illegal;
    logic          misalign;
    logic          acc_err;
    logic [AW-1:0] base;
    logic [31:0]   rd_word;
    logic [31:0]   load_val;

    always_comb begin
        acc_size = 3'd4;
        case (lat_f3[1:0])
            2'b00:   acc_size = 3'd1;
            2'b01:   acc_size = 3'd2;
            default: acc_size = 3'd4;
        endcase
    end

    // Range compare carries one extra bit so addresses near the top of ADDR_W cannot wrap into range.
    assign last_byte = {1'b0, lat_addr} + (ADDR_W+1)'(acc_size) - (ADDR_W+1)'(1);
    assign range_err = last_byte >= (ADDR_W+1)'(DEPTH_BYTES);
    assign illegal   = (lat_f3 == 3'b011) || (lat_f3[2:1] == 2'b11) || (lat_we && lat_f3[2]);

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misalign = ((lat_f3[1:0] == 2'b01) && lat_addr[0]) ||
                      ((lat_f3[1:0] == 2'b10) && (lat_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign acc_err = illegal || range_err || misalign;
    assign base    = lat_addr[AW-1:0];
    assign rd_word = {mem[base + AW'(3)], mem[base + AW'(2)], mem[base + AW'(1)], mem[base]};

    always_comb begin
        load_val = 32'd0;
        case (lat_f3)
            3'b000:  load_val = {{24{rd_word[7]}}, rd_word[7:0]};
            3'b100:  load_val = {24'd0, rd_word[7:0]};
            3'b001:  load_val = {{16{rd_word[15]}}, rd_word[15:0]};
            3'b101:  load_val = {16'd0, rd_word[15:0]};
            3'b010:  load_val = rd_word;
            default: load_val = 32'd0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset) begin
            state     <= CLEAR;
            clr_cnt   <= '0;
            wait_cnt  <= 4'd0;
            init_done <= 1'b0;
            lat_we    <= 1'b0;
            lat_f3    <= 3'd0;
            lat_addr  <= '0;
            lat_data  <= 32'd0;
        end else begin
            case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + WW'(1);
                    if (&clr_cnt) begin
                        state     <= IDLE;
                        init_done <= 1'b1;
                    end
                end
                IDLE: begin
                    if (req_i) begin
                        lat_we   <= we_i;
                        lat_f3   <= funct3_i;
                        lat_addr <= addr_i;
                        lat_data <= data_i;
                        wait_cnt <= 4'(WAIT_STATES);
                        state    <= (WAIT_STATES > 0) ? WAIT : RESP;
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt <= 4'd1) begin
                        state <= RESP;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A reset on the RESP edge drops the store along with the response.
    always_ff @(posedge clk_i) begin
        if (!reset) begin
            if (state == CLEAR) begin
                for (int b = 0; b < 4; b++) begin
                    mem[{clr_cnt, 2'(b)}] <= 8'd0;
                end
            end else if ((state == RESP) && lat_we && !acc_err) begin
                for (int i = 0; i < 4; i++) begin
                    if (i < int'(acc_size)) begin
                        mem[base + AW'(i)] <= lat_data[8*i +: 8];
                    end
                end
            end
        end
    end

    assign ready_o     = (state == IDLE);
    assign valid_o     = (state == RESP);
    assign err_o       = valid_o && acc_err;
    assign data_o      = (valid_o && !lat_we && !acc_err) ? load_val : 32'd0;
    assign init_done_o = init_done;

    logic [ADDR_W-1:0] dbg_aligned;
    logic [AW-1:0]     dbg_base;
    logic              dbg_in;

    assign dbg_aligned = dbg_addr_i & ~ADDR_W'(3);
    assign dbg_base    = dbg_aligned[AW-1:0];
    assign dbg_in      = {1'b0, dbg_aligned} < (ADDR_W+1)'(DEPTH_BYTES);
    assign dbg_data_o  = dbg_in ? {mem[dbg_base + AW'(3)], mem[dbg_base + AW'(2)],
                                   mem[dbg_base + AW'(1)], mem[dbg_base]} : 32'd0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl (64 bytes, two wait states); honours DMEM_MISALIGN_TRAP_EN when defined.
module tb_dmem_ctrl;

    localparam int WS = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  f3 = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] dbg_addr = 32'd0;
    logic        ready;
    logic        valid;
    logic [31:0] rdata;
    logic        err;
    logic        init_done;
    logic [31:0] dbg_data;

    int n_checks = 0;
    int n_errs   = 0;
    int n_valid  = 0;
    int nv_snap  = 0;

    dmem_ctrl #(.DEPTH_BYTES(64), .ADDR_W(32), .WAIT_STATES(WS)) dut (
        .clk_i(clk), .reset(reset), .req_i(req), .we_i(we), .funct3_i(f3),
        .addr_i(addr), .data_i(wdata), .ready_o(ready), .valid_o(valid),
        .data_o(rdata), .err_o(err), .init_done_o(init_done),
        .dbg_addr_i(dbg_addr), .dbg_data_o(dbg_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (valid === 1'b1) n_valid <= n_valid + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s: got=%08h want=%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input string tag, input logic [31:0] a, input logic [31:0] exp);
        dbg_addr = a;
        #1;
        check(tag, dbg_data, exp);
    endtask

    // Latency is counted in edges after the accepting edge; the response cycle follows edge T+WS.
    task automatic access(input string tag, input logic w, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic exp_err, input logic [31:0] exp_data);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check({tag, ":rdy"}, {31'd0, ready}, 32'd1);
        req = 1'b1; we = w; f3 = f; addr = a; wdata = d;
        tick();
        req = 1'b0;
        n = 0;
        while (valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check({tag, ":lat"}, 32'(n), 32'(WS));
        check({tag, ":err"}, {31'd0, err}, {31'd0, exp_err});
        check({tag, ":dat"}, rdata, exp_data);
        tick();
        check({tag, ":pulse"}, {31'd0, valid}, 32'd0);
    endtask

    initial begin
        repeat (3) tick();
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_data",  rdata, 32'd0);
        check("rst_err",   {31'd0, err}, 32'd0);
        check("rst_init",  {31'd0, init_done}, 32'd0);

        // Store request held during CLEAR must be ignored.
        req = 1'b1; we = 1'b1; f3 = 3'b010; addr = 32'h0; wdata = 32'hFFFF_FFFF;
        reset = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i == 8) req = 1'b0;
            if (i == 15) begin
                check("clr15_ready", {31'd0, ready}, 32'd0);
                check("clr15_init",  {31'd0, init_done}, 32'd0);
            end
        end
        check("clr16_ready", {31'd0, ready}, 32'd1);
        check("clr16_init",  {31'd0, init_done}, 32'd1);
        check("clr_novalid", 32'(n_valid), 32'd0);
        for (int a = 0; a < 64; a += 4) peek("clr_zero", 32'(a), 32'd0);

        access("sw10",  1'b1, 3'b010, 32'h10, 32'h8899AABB, 1'b0, 32'h0);
        peek("dbg10", 32'h10, 32'h8899AABB);
        peek("dbg_oor50", 32'h50, 32'h0);
        access("lb12",  1'b0, 3'b000, 32'h12, 32'h0, 1'b0, 32'hFFFFFF99);
        access("lbu12", 1'b0, 3'b100, 32'h12, 32'h0, 1'b0, 32'h00000099);
        access("lh10",  1'b0, 3'b001, 32'h10, 32'h0, 1'b0, 32'hFFFFAABB);
        access("lhu10", 1'b0, 3'b101, 32'h10, 32'h0, 1'b0, 32'h0000AABB);
        access("sb13",  1'b1, 3'b000, 32'h13, 32'h0000007F, 1'b0, 32'h0);
        access("lw_sb", 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'h7F99AABB);
        access("sh10",  1'b1, 3'b001, 32'h10, 32'hFFFF1234, 1'b0, 32'h0);
        access("lw_sh", 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'h7F991234);

        access("lw3e",  1'b0, 3'b010, 32'h3E, 32'h0, 1'b1, 32'h0);
        access("sw40",  1'b1, 3'b010, 32'h40, 32'h11223344, 1'b1, 32'h0);
        peek("dbg3c_keep", 32'h3C, 32'h0);
        access("ld011", 1'b0, 3'b011, 32'h10, 32'h0, 1'b1, 32'h0);
        access("st100", 1'b1, 3'b100, 32'h10, 32'hAAAAAAAA, 1'b1, 32'h0);
        peek("dbg10_keep", 32'h10, 32'h7F991234);
        access("lw3c",  1'b0, 3'b010, 32'h3C, 32'h0, 1'b0, 32'h0);
        access("sb3f",  1'b1, 3'b000, 32'h3F, 32'h000000A5, 1'b0, 32'h0);
        peek("dbg3c_sb", 32'h3C, 32'hA5000000);
        access("lbu3f", 1'b0, 3'b100, 32'h3F, 32'h0, 1'b0, 32'h000000A5);
        access("lh3f",  1'b0, 3'b001, 32'h3F, 32'h0, 1'b1, 32'h0);
        access("lwtop", 1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, 1'b1, 32'h0);
        access("lbtop", 1'b0, 3'b000, 32'hFFFFFFFF, 32'h0, 1'b1, 32'h0);

`ifdef DMEM_MISALIGN_TRAP_EN
        access("sw21",  1'b1, 3'b010, 32'h21, 32'hDEADBEEF, 1'b1, 32'h0);
        peek("dbg20_mis", 32'h20, 32'h0);
        peek("dbg24_mis", 32'h24, 32'h0);
        access("lw21",  1'b0, 3'b010, 32'h21, 32'h0, 1'b1, 32'h0);
        access("lh21",  1'b0, 3'b001, 32'h21, 32'h0, 1'b1, 32'h0);
`else
        access("sw21",  1'b1, 3'b010, 32'h21, 32'hDEADBEEF, 1'b0, 32'h0);
        peek("dbg20_mis", 32'h20, 32'hADBEEF00);
        peek("dbg24_mis", 32'h24, 32'h000000DE);
        access("lw21",  1'b0, 3'b010, 32'h21, 32'h0, 1'b0, 32'hDEADBEEF);
        access("lh21",  1'b0, 3'b001, 32'h21, 32'h0, 1'b0, 32'hFFFFBEEF);
`endif

        // Reset while a store sits in WAIT, then a second reset part-way through CLEAR.
        nv_snap = n_valid;
        req = 1'b1; we = 1'b1; f3 = 3'b010; addr = 32'h08; wdata = 32'hCAFEF00D;
        tick();
        req = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rstw_ready", {31'd0, ready}, 32'd0);
        check("rstw_valid", {31'd0, valid}, 32'd0);
        check("rstw_init",  {31'd0, init_done}, 32'd0);
        req = 1'b1; we = 1'b1; f3 = 3'b010; addr = 32'h0C; wdata = 32'h55555555;
        dbg_addr = 32'h10;
        tick();
        tick();
        check("partial10", dbg_data, 32'h7F991234);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i == 8) req = 1'b0;
            if (i == 15) check("reclr15_ready", {31'd0, ready}, 32'd0);
        end
        check("reclr_ready", {31'd0, ready}, 32'd1);
        check("reclr_init",  {31'd0, init_done}, 32'd1);
        check("reclr_novalid", 32'(n_valid), 32'(nv_snap));
        peek("reclr08", 32'h08, 32'h0);
        peek("reclr0c", 32'h0C, 32'h0);
        peek("reclr10", 32'h10, 32'h0);
        access("lw08",  1'b0, 3'b010, 32'h08, 32'h0, 1'b0, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Byte-addressable, parametrised data memory for the RV32 core's MEM stage. Supports the RV32I load/store widths (funct3-encoded) with sign/zero extension, a request/response handshake with configurable wait states, and a self-clearing initialisation sequence after reset. It also provides a combinational debug word-read port for the testbench and top-level observation.

## Interface
- DEPTH_BYTES, 1024, memory size in bytes; power of two, multiple of 4, at least 8.
- ADDR_W, 32, width of the request and debug addresses.
- WAIT_STATES, 0, extra cycles between request acceptance and response; range 0..15.
- clk_i  in  1  clock. Single clock domain. Reset is synchronous and active-high.
- reset  in  1  synchronous, active-high reset.
- req_i  in  1  request strobe; sampled only while ready_o=1.
- we_i  in  1  1 = store, 0 = load.
- funct3_i  in  3  access size and sign (RV32I load/store encoding).
- addr_i  in  ADDR_W  byte address.
- data_i  in  32  store data; the low bytes are used for SB/SH.
- ready_o  out  1  block can accept a request this cycle.
- valid_o  out  1  one-cycle response pulse.
- data_o  out  32  load result, extended; 0 unless valid_o=1 and the access is a load without error.
- err_o  out  1  valid only with valid_o; the access faulted and had no effect.
- init_done_o  out  1  memory clear has completed.
- dbg_addr_i  in  ADDR_W  debug byte address; bits [1:0] are ignored (word-aligned).
- dbg_data_o  out  32  combinational little-endian word at dbg_addr_i; 0 if out of range.

## Operation
- FSM states: CLEAR, IDLE, WAIT, RESP.
- CLEAR
  - Entered on reset.
  - Writes 0 to one 32-bit word per cycle, using word counter 0..DEPTH_BYTES/4-1.
  - Moves to IDLE after the last word; init_done_o goes high at that transition and stays high until the next reset.
- IDLE
  - ready_o=1.
  - On req_i=1, latches we_i, funct3_i, addr_i and data_i, and loads the wait counter with WAIT_STATES.
  - Goes to WAIT if WAIT_STATES>0, otherwise to RESP.
- WAIT: decrements the counter; goes to RESP when the counter reaches 1.
- RESP
  - valid_o=1 for exactly one cycle, then returns to IDLE.
  - ready_o=0 in every state except IDLE.
- Loads
  - 000 LB and 100 LBU: 1 byte. 001 LH and 101 LHU: 2 bytes. 010 LW: 4 bytes.
  - Data is little-endian: byte at addr is bits [7:0].
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - Read data is sampled from memory in the RESP cycle.
- Stores
  - 000 SB, 001 SH, 010 SW.
  - Bytes are written at the clock edge that ends the RESP cycle.
- Errors (err_o=1, no write, data_o=0):
  - illegal funct3: 011, 11x, or 1xx on a store;
  - out of range: addr + size - 1 ≥ DEPTH_BYTES, with the compare done at full ADDR_W+1 width so there is no wrap-around;
  - misalignment, only when the misalignment trap is enabled (see Configuration).
- A load issued in the cycle after a store's RESP returns the newly written data.

## Timing
- Reset values: ready_o=0, valid_o=0, data_o=0, err_o=0, init_done_o=0. Wait counter and latched request are cleared.
- First ready_o=1 occurs DEPTH_BYTES/4 cycles after reset deasserts.
- Latency: a request accepted at edge T gives valid_o high in cycle T+1+WAIT_STATES.
- Throughput: one access per WAIT_STATES+2 cycles.
- req_i while ready_o=0 is ignored; it is neither queued nor erroneous.
- Reset asserted mid-access:
  - the pending store is dropped and valid_o is never produced;
  - the FSM returns to CLEAR and the clear restarts from word 0;
  - a reset during CLEAR also restarts the clear from word 0.
- dbg_data_o is purely combinational.
  - It shows a store on the cycle after the write edge.
  - During CLEAR it shows partially cleared contents.

## Configuration
- DMEM_MISALIGN_TRAP_EN defined:
  - a halfword access with addr[0]=1, or a word access with addr[1:0]≠0, completes with err_o=1;
  - no bytes are written and data_o=0.
- DMEM_MISALIGN_TRAP_EN undefined:
  - misaligned accesses proceed bytewise over addr..addr+size-1, subject only to the range check;
  - err_o never signals misalignment.

## Test plan
- Reset, DEPTH_BYTES=64 → init_done_o and ready_o rise exactly 16 cycles after reset drops; dbg_data_o=0 at every word address.
- WAIT_STATES=2: SW 0x8899AABB @0x10, then LB @0x12, LBU @0x12, LH @0x10, LHU @0x10 → each valid_o arrives 3 cycles after acceptance. Required data_o values:
  - LB @0x12 = 0xFFFFFF99;
  - LBU @0x12 = 0x00000099;
  - LH @0x10 = 0xFFFFAABB;
  - LHU @0x10 = 0x0000AABB.
- SB 0x7F @0x13 over 0x8899AABB → LW @0x10 = 0x7F99AABB; SH 0x1234 @0x10 → LW @0x10 = 0x7F991234.
- Range and illegal checks with DEPTH_BYTES=64:
  - LW @0x3E → err_o=1, data_o=0;
  - SW @0x40 → err_o=1, dbg_data_o @0x3C unchanged;
  - funct3=011 load → err_o=1.
- Misaligned SW 0xDEADBEEF @0x21:
  - with DMEM_MISALIGN_TRAP_EN → err_o=1, memory unchanged;
  - without it → bytes 0x21..0x24 = EF,BE,AD,DE.
- Reset in the WAIT state of a SW → no valid_o, word still 0 after the clear completes; req_i during CLEAR is ignored.
